// File: rtl/prog_clk_divider.sv
// ---------------------------------------------------------------------------
// prog_clk_divider
// Runtime-programmable integer clock divider. Divides clk_50MHz by N >= 2 and
// produces a registered divided clock (low floor(N/2) cycles, high the rest)
// plus a one-cycle tick strobe in the source domain, aligned with the rising
// edge of clk_out. A new divisor requested while counting is queued and only
// applied at the next period boundary, so no runt or stretched period appears.
//
// Ports:
//   clk_50MHz  in   source clock, the only clock of the block
//   rst_n      in   synchronous active-low reset, highest priority
//   en         in   count enable; 0 freezes counter and clk_out
//   sync_clr   in   phase restart to the start of a period
//   div_load   in   strobe; div_in sampled when high
//   div_in     in   requested divisor N (CNT_W bits)
//   clk_out    out  divided clock, registered
//   tick       out  one-cycle pulse when clk_out rises
//   div_active out  divisor currently in force
//   pending    out  a legal divisor is queued for the next wrap
//   div_err    out  one-cycle pulse: last div_load carried a divisor < 2
// ---------------------------------------------------------------------------
module prog_clk_divider #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 50
) (
  input  logic             clk_50MHz,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             div_load,
  input  logic [CNT_W-1:0] div_in,
  output logic             clk_out,
  output logic             tick,
  output logic [CNT_W-1:0] div_active,
  output logic             pending,
  output logic             div_err
);

  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO     = CNT_W'(2);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] div_r;
  logic [CNT_W-1:0] pend_div_r;
  logic             pending_r;
  logic             clk_r;
  logic             tick_r;
  logic             err_r;

  logic [CNT_W-1:0] cnt_nxt_s;
  logic [CNT_W-1:0] div_nxt_s;
  logic [CNT_W-1:0] pend_div_nxt_s;
  logic             pending_nxt_s;
  logic             clk_nxt_s;
  logic             tick_nxt_s;
  logic             err_nxt_s;

  logic [CNT_W-1:0] half_s;
  logic [CNT_W-1:0] last_s;
  logic [CNT_W-1:0] cnt_inc_s;
  logic             wrap_s;
  logic             legal_s;
  logic             illegal_s;

  // Decode of the current period: midpoint, last count and load legality.
  always_comb begin
    half_s    = div_r >> 1;
    last_s    = div_r - ONE;
    cnt_inc_s = cnt_r + ONE;
    wrap_s    = en && (cnt_r == last_s);
    legal_s   = div_load && (div_in >= TWO);
    illegal_s = div_load && (div_in < TWO);
  end

  // Next-state selection: sync_clr, then load/wrap, then normal counting.
  always_comb begin
    cnt_nxt_s      = cnt_r;
    div_nxt_s      = div_r;
    pend_div_nxt_s = pend_div_r;
    pending_nxt_s  = pending_r;
    clk_nxt_s      = clk_r;
    tick_nxt_s     = 1'b0;
    err_nxt_s      = 1'b0;
    if (sync_clr) begin
      cnt_nxt_s = ZERO;
      clk_nxt_s = 1'b0;
      // A queued divisor takes effect here exactly as it would at a wrap.
      if (pending_r) begin
        div_nxt_s     = pend_div_r;
        pending_nxt_s = 1'b0;
      end else begin
        div_nxt_s = div_r;
      end
    end else begin
      err_nxt_s = illegal_s;
      if (legal_s && !en) begin
        // Frozen divider: nothing is mid-period, so apply at once.
        div_nxt_s     = div_in;
        cnt_nxt_s     = ZERO;
        clk_nxt_s     = 1'b0;
        pending_nxt_s = 1'b0;
      end else if (wrap_s) begin
        cnt_nxt_s = ZERO;
        clk_nxt_s = 1'b0;
        // A load on the wrap edge is newer than anything queued.
        if (legal_s) begin
          div_nxt_s     = div_in;
          pending_nxt_s = 1'b0;
        end else if (pending_r) begin
          div_nxt_s     = pend_div_r;
          pending_nxt_s = 1'b0;
        end else begin
          div_nxt_s = div_r;
        end
      end else if (en) begin
        cnt_nxt_s  = cnt_inc_s;
        clk_nxt_s  = (cnt_inc_s >= half_s);
        tick_nxt_s = (cnt_inc_s == half_s);
        if (legal_s) begin
          pend_div_nxt_s = div_in;
          pending_nxt_s  = 1'b1;
        end else begin
          pending_nxt_s = pending_r;
        end
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_50MHz) begin
    if (!rst_n) begin
      cnt_r      <= ZERO;
      div_r      <= DEF_DIV;
      pend_div_r <= ZERO;
      pending_r  <= 1'b0;
      clk_r      <= 1'b0;
      tick_r     <= 1'b0;
      err_r      <= 1'b0;
    end else begin
      cnt_r      <= cnt_nxt_s;
      div_r      <= div_nxt_s;
      pend_div_r <= pend_div_nxt_s;
      pending_r  <= pending_nxt_s;
      clk_r      <= clk_nxt_s;
      tick_r     <= tick_nxt_s;
      err_r      <= err_nxt_s;
    end
  end

  assign clk_out    = clk_r;
  assign tick       = tick_r;
  assign div_active = div_r;
  assign pending    = pending_r;
  assign div_err    = err_r;

endmodule
